// File: rtl/hazard_fwd_ctrl.sv
// Operand forwarding and pipeline stall/bubble control for the 5-stage RV32I pipeline.
// Define HAZARD_PERF_CNT_EN to add saturating memory-stall and load-use-stall cycle counters.
module hazard_fwd_ctrl #(
  parameter int unsigned REG_IDX_W       = 5,
  parameter int unsigned LOAD_USE_CYCLES = 1,
  parameter int unsigned PERF_CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_IDX_W-1:0]  rs1_id_ex,
  input  logic [REG_IDX_W-1:0]  rs2_id_ex,
  input  logic [REG_IDX_W-1:0]  rd_ex_mem,
  input  logic [REG_IDX_W-1:0]  rd_mem_wb,
  input  logic                  load_regfile_ex_mem,
  input  logic                  load_regfile_mem_wb,
  input  logic [REG_IDX_W-1:0]  rd_id_ex,
  input  logic                  mem_read_id_ex,
  input  logic [REG_IDX_W-1:0]  rs1_if_id,
  input  logic [REG_IDX_W-1:0]  rs2_if_id,
  input  logic                  mem_write_if_id,
  input  logic                  branch_flush,
  input  logic                  inst_mem_read,
  input  logic                  inst_mem_resp,
  input  logic                  data_mem_read,
  input  logic                  data_mem_write,
  input  logic                  data_mem_resp,
  output logic [1:0]            rs1_fwd_sel,
  output logic [1:0]            rs2_fwd_sel,
  output logic                  stall_pc,
  output logic                  stall_if_id,
  output logic                  stall_id_ex,
  output logic                  stall_ex_mem,
  output logic                  stall_mem_wb,
  output logic                  bubble_control
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_mem_stall_cycles,
  output logic [PERF_CNT_W-1:0] perf_lu_stall_cycles
`endif
);

  typedef enum logic {
    RUN,
    LU_STALL
  } state_e;

  localparam logic [1:0] LU_CNT_INIT = 2'(LOAD_USE_CYCLES - 1);
  localparam bit         LU_MULTI    = (LOAD_USE_CYCLES > 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic mem_stall;
  logic lu_hazard;
  logic ex_fwd_rs1, ex_fwd_rs2, wb_fwd_rs1, wb_fwd_rs2;

  always_comb begin
    mem_stall = (inst_mem_read & ~inst_mem_resp)
              | ((data_mem_read | data_mem_write) & ~data_mem_resp);
    // Store data (rs2) is forwarded later in EX/MEM, so it alone never stalls.
    lu_hazard = mem_read_id_ex && (rd_id_ex != '0)
              && ((rd_id_ex == rs1_if_id)
                  || ((rd_id_ex == rs2_if_id) && !mem_write_if_id));
  end

  always_comb begin
    ex_fwd_rs1 = load_regfile_ex_mem && (rd_ex_mem != '0) && (rd_ex_mem == rs1_id_ex);
    ex_fwd_rs2 = load_regfile_ex_mem && (rd_ex_mem != '0) && (rd_ex_mem == rs2_id_ex);
    wb_fwd_rs1 = load_regfile_mem_wb && (rd_mem_wb != '0) && (rd_mem_wb == rs1_id_ex);
    wb_fwd_rs2 = load_regfile_mem_wb && (rd_mem_wb != '0) && (rd_mem_wb == rs2_id_ex);

    rs1_fwd_sel = 2'd0;
    rs2_fwd_sel = 2'd0;
    if (!rst) begin
      if (ex_fwd_rs1)      rs1_fwd_sel = 2'd1;
      else if (wb_fwd_rs1) rs1_fwd_sel = 2'd2;
      if (ex_fwd_rs2)      rs2_fwd_sel = 2'd1;
      else if (wb_fwd_rs2) rs2_fwd_sel = 2'd2;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_pc       = 1'b0;
    stall_if_id    = 1'b0;
    stall_id_ex    = 1'b0;
    stall_ex_mem   = 1'b0;
    stall_mem_wb   = 1'b0;
    bubble_control = 1'b0;

    if (rst) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (mem_stall) begin
      // Whole pipe freezes; the load-use sequence resumes where it left off.
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      stall_mem_wb = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (!branch_flush && lu_hazard) begin
            stall_pc       = 1'b1;
            stall_if_id    = 1'b1;
            bubble_control = 1'b1;
            if (LU_MULTI) begin
              state_d = LU_STALL;
              cnt_d   = LU_CNT_INIT;
            end
          end
        end
        LU_STALL: begin
          if (branch_flush) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            stall_pc       = 1'b1;
            stall_if_id    = 1'b1;
            bubble_control = 1'b1;
            if (cnt_q == 2'd1) begin
              state_d = RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 2'd1;
            end
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] perf_mem_q, perf_mem_d;
  logic [PERF_CNT_W-1:0] perf_lu_q, perf_lu_d;

  always_comb begin
    perf_mem_d = perf_mem_q;
    perf_lu_d  = perf_lu_q;
    if (mem_stall && (perf_mem_q != '1))
      perf_mem_d = perf_mem_q + PERF_CNT_W'(1);
    if (bubble_control && (perf_lu_q != '1))
      perf_lu_d = perf_lu_q + PERF_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_mem_q <= '0;
      perf_lu_q  <= '0;
    end else begin
      perf_mem_q <= perf_mem_d;
      perf_lu_q  <= perf_lu_d;
    end
  end

  assign perf_mem_stall_cycles = perf_mem_q;
  assign perf_lu_stall_cycles  = perf_lu_q;
`else
  localparam int unsigned perf_cnt_w_unused = PERF_CNT_W;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed self-checking bench for hazard_fwd_ctrl built with LOAD_USE_CYCLES=3.
module tb_hazard_fwd_ctrl;

  localparam int unsigned RW = 5;
  localparam int unsigned PW = 32;

  // ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, bubble_control}
  localparam logic [5:0] CTL_NONE = 6'b000000;
  localparam logic [5:0] CTL_LU   = 6'b110001;
  localparam logic [5:0] CTL_MEM  = 6'b111110;

  logic clk = 1'b0;
  logic rst;
  logic [RW-1:0] rs1_id_ex, rs2_id_ex, rd_ex_mem, rd_mem_wb, rd_id_ex, rs1_if_id, rs2_if_id;
  logic load_regfile_ex_mem, load_regfile_mem_wb, mem_read_id_ex, mem_write_if_id, branch_flush;
  logic inst_mem_read, inst_mem_resp, data_mem_read, data_mem_write, data_mem_resp;
  logic [1:0] rs1_fwd_sel, rs2_fwd_sel;
  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, bubble_control;
`ifdef HAZARD_PERF_CNT_EN
  logic [PW-1:0] perf_mem_stall_cycles, perf_lu_stall_cycles;
`endif

  logic [5:0] ctl;
  assign ctl = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb, bubble_control};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(
    .REG_IDX_W(RW),
    .LOAD_USE_CYCLES(3),
    .PERF_CNT_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rs1_id_ex(rs1_id_ex),
    .rs2_id_ex(rs2_id_ex),
    .rd_ex_mem(rd_ex_mem),
    .rd_mem_wb(rd_mem_wb),
    .load_regfile_ex_mem(load_regfile_ex_mem),
    .load_regfile_mem_wb(load_regfile_mem_wb),
    .rd_id_ex(rd_id_ex),
    .mem_read_id_ex(mem_read_id_ex),
    .rs1_if_id(rs1_if_id),
    .rs2_if_id(rs2_if_id),
    .mem_write_if_id(mem_write_if_id),
    .branch_flush(branch_flush),
    .inst_mem_read(inst_mem_read),
    .inst_mem_resp(inst_mem_resp),
    .data_mem_read(data_mem_read),
    .data_mem_write(data_mem_write),
    .data_mem_resp(data_mem_resp),
    .rs1_fwd_sel(rs1_fwd_sel),
    .rs2_fwd_sel(rs2_fwd_sel),
    .stall_pc(stall_pc),
    .stall_if_id(stall_if_id),
    .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem),
    .stall_mem_wb(stall_mem_wb),
    .bubble_control(bubble_control)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_mem_stall_cycles(perf_mem_stall_cycles),
    .perf_lu_stall_cycles(perf_lu_stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_id_ex = '0; rs2_id_ex = '0; rd_ex_mem = '0; rd_mem_wb = '0;
    rd_id_ex = '0; rs1_if_id = '0; rs2_if_id = '0;
    load_regfile_ex_mem = 1'b0; load_regfile_mem_wb = 1'b0;
    mem_read_id_ex = 1'b0; mem_write_if_id = 1'b0; branch_flush = 1'b0;
    inst_mem_read = 1'b0; inst_mem_resp = 1'b0;
    data_mem_read = 1'b0; data_mem_write = 1'b0; data_mem_resp = 1'b0;
  endtask

  task automatic set_lu_hazard();
    mem_read_id_ex = 1'b1; rd_id_ex = 5'd7; rs1_if_id = 5'd7;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with forwarding, load-use and memory-stall conditions all present.
    clear_inputs();
    rst = 1'b1;
    load_regfile_ex_mem = 1'b1; rd_ex_mem = 5'd5; rs1_id_ex = 5'd5; rs2_id_ex = 5'd5;
    set_lu_hazard();
    data_mem_read = 1'b1;
    tick();
    chk("rst_ctl", 32'(ctl), 32'(CTL_NONE));
    chk("rst_fwd1", 32'(rs1_fwd_sel), 32'd0);
    chk("rst_fwd2", 32'(rs2_fwd_sel), 32'd0);
    tick();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk("post_rst_ctl", 32'(ctl), 32'(CTL_NONE));
    tick();

    // Forwarding priority and rd!=0 gating.
    load_regfile_ex_mem = 1'b1; rd_ex_mem = 5'd5;
    load_regfile_mem_wb = 1'b1; rd_mem_wb = 5'd5;
    rs1_id_ex = 5'd5; rs2_id_ex = 5'd0;
    #1;
    chk("fwd_prio_rs1", 32'(rs1_fwd_sel), 32'd1);
    chk("fwd_prio_rs2", 32'(rs2_fwd_sel), 32'd0);
    tick();
    rd_ex_mem = 5'd0;
    #1;
    chk("fwd_wb_rs1", 32'(rs1_fwd_sel), 32'd2);
    tick();
    load_regfile_ex_mem = 1'b0; rd_ex_mem = 5'd9; rs2_id_ex = 5'd9;
    load_regfile_mem_wb = 1'b0;
    #1;
    chk("fwd_nowe_rs1", 32'(rs1_fwd_sel), 32'd0);
    chk("fwd_nowe_rs2", 32'(rs2_fwd_sel), 32'd0);
    tick();
    load_regfile_ex_mem = 1'b1;
    #1;
    chk("fwd_ex_rs2", 32'(rs2_fwd_sel), 32'd1);
    tick();
    clear_inputs();
    load_regfile_ex_mem = 1'b1; load_regfile_mem_wb = 1'b1;
    #1;
    chk("fwd_x0_rs1", 32'(rs1_fwd_sel), 32'd0);
    chk("fwd_x0_rs2", 32'(rs2_fwd_sel), 32'd0);
    tick();
    clear_inputs();

    // Load-use: three consecutive bubbles, then release.
    set_lu_hazard();
    #1;
    chk("lu_c1", 32'(ctl), 32'(CTL_LU));
    tick();
    clear_inputs();
    #1;
    chk("lu_c2", 32'(ctl), 32'(CTL_LU));
    tick();
    chk("lu_c3", 32'(ctl), 32'(CTL_LU));
    tick();
    chk("lu_done", 32'(ctl), 32'(CTL_NONE));
    tick();

    // Store exemption on rs2, not on rs1; rd=0 never hazards.
    mem_read_id_ex = 1'b1; rd_id_ex = 5'd4; mem_write_if_id = 1'b1;
    rs2_if_id = 5'd4; rs1_if_id = 5'd2;
    #1;
    chk("st_rs2_exempt", 32'(ctl), 32'(CTL_NONE));
    tick();
    clear_inputs();
    mem_read_id_ex = 1'b1; rd_id_ex = 5'd0; rs1_if_id = 5'd0;
    #1;
    chk("lu_rd0", 32'(ctl), 32'(CTL_NONE));
    tick();
    mem_read_id_ex = 1'b1; rd_id_ex = 5'd4; mem_write_if_id = 1'b1;
    rs2_if_id = 5'd4; rs1_if_id = 5'd4;
    #1;
    chk("st_rs1_stall", 32'(ctl), 32'(CTL_LU));
    tick();
    clear_inputs();
    tick();
    tick();
    chk("st_done", 32'(ctl), 32'(CTL_NONE));
    tick();

    // Memory stall in the middle of a load-use sequence.
    set_lu_hazard();
    #1;
    chk("mlu_c1", 32'(ctl), 32'(CTL_LU));
    tick();
    clear_inputs();
    data_mem_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("mlu_mem%0d", i), 32'(ctl), 32'(CTL_MEM));
      tick();
    end
    data_mem_read = 1'b0;
    #1;
    chk("mlu_c2", 32'(ctl), 32'(CTL_LU));
    tick();
    chk("mlu_c3", 32'(ctl), 32'(CTL_LU));
    tick();
    chk("mlu_done", 32'(ctl), 32'(CTL_NONE));
    inst_mem_read = 1'b1;
    #1;
    chk("imem_stall", 32'(ctl), 32'(CTL_MEM));
    tick();
    clear_inputs();

    // Branch flush while in LU_STALL, and flush masking a hazard in RUN.
    set_lu_hazard();
    #1;
    chk("fl_c1", 32'(ctl), 32'(CTL_LU));
    tick();
    clear_inputs();
    branch_flush = 1'b1;
    #1;
    chk("fl_lu_stall", 32'(ctl), 32'(CTL_NONE));
    tick();
    branch_flush = 1'b0;
    #1;
    chk("fl_back_run", 32'(ctl), 32'(CTL_NONE));
    tick();
    set_lu_hazard();
    branch_flush = 1'b1;
    #1;
    chk("fl_run_mask", 32'(ctl), 32'(CTL_NONE));
    tick();
    clear_inputs();
    #1;
    chk("fl_run_stay", 32'(ctl), 32'(CTL_NONE));
    tick();

    // Reset asserted while in LU_STALL.
    set_lu_hazard();
    tick();
    clear_inputs();
    load_regfile_ex_mem = 1'b1; rd_ex_mem = 5'd3; rs1_id_ex = 5'd3;
    rst = 1'b1;
    #1;
    chk("rst_lu_ctl", 32'(ctl), 32'(CTL_NONE));
    chk("rst_lu_fwd", 32'(rs1_fwd_sel), 32'd0);
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("rst_lu_run", 32'(ctl), 32'(CTL_NONE));
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_perf_mem", perf_mem_stall_cycles, 32'd0);
    chk("rst_perf_lu", perf_lu_stall_cycles, 32'd0);
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
